// File: rtl/wrr_pkg.sv
// Shared constants, types and helpers for the weighted round-robin requestor client.
package wrr_pkg;
  localparam int N          = 32;
  localparam int PRIORITY_W = 4;
  localparam int ID_BITS    = $clog2(N);
  localparam int CNT_W      = 4;

  typedef logic [ID_BITS-1:0]    id_t;
  typedef logic [PRIORITY_W-1:0] prio_t;
  typedef logic [CNT_W-1:0]      cnt_t;
  typedef logic [N-1:0]          vec_t;

  function automatic logic is_onehot(input vec_t v);
    return (v != '0) && ((v & (v - vec_t'(1))) == '0);
  endfunction
endpackage

// File: rtl/wrr_pend_counter.sv
// Per-requestor pending-transaction counter; simultaneous inc and dec leave it unchanged.
module wrr_pend_counter
  import wrr_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output cnt_t cnt,
  output logic nonzero,
  output logic full
);
  cnt_t cnt_q, cnt_d;

  // The parent never raises inc when full nor dec when zero, so no saturation logic here.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec)      cnt_d = cnt_q + cnt_t'(1);
    else if (dec && !inc) cnt_d = cnt_q - cnt_t'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt     = cnt_q;
  assign nonzero = (cnt_q != '0);
  assign full    = (cnt_q == '1);
endmodule

// File: rtl/wrr_client.sv
// Requestor-side client of the WRR arbiter: pending counts drive req, legal grants are acked
// into a registered ID stream, and weight writes are serialised so prio_upt never meets ack.
module wrr_client
  import wrr_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enq_valid,
  input  logic [ID_BITS-1:0]    enq_id,
  output logic                  enq_ready,
  output logic [N-1:0]          req,
  input  logic [N-1:0]          gnt_w,
  input  logic [ID_BITS-1:0]    gnt_id,
  output logic                  ack,
  output logic                  dn_valid,
  output logic [ID_BITS-1:0]    dn_id,
  input  logic                  dn_ready,
  input  logic                  cfg_valid,
  input  logic [ID_BITS-1:0]    cfg_id,
  input  logic [PRIORITY_W-1:0] cfg_prio,
  output logic                  cfg_ready,
  output logic [PRIORITY_W-1:0] prio,
  output logic [ID_BITS-1:0]    prio_id,
  output logic                  prio_upt,
  output logic                  err_gnt
);
  vec_t  inc_vec, dec_vec, nz_vec, full_vec;
  cnt_t  cnt_arr [N];
  logic  gnt_ok, dn_free;

  logic  dn_valid_q, dn_valid_d;
  id_t   dn_id_q, dn_id_d;
  logic  cfg_pend_q, cfg_pend_d;
  prio_t prio_q, prio_d;
  id_t   prio_id_q, prio_id_d;
  logic  err_gnt_q, err_gnt_d;

  for (genvar g = 0; g < N; g++) begin : g_cnt
    wrr_pend_counter u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc     (inc_vec[g]),
      .dec     (dec_vec[g]),
      .cnt     (cnt_arr[g]),
      .nonzero (nz_vec[g]),
      .full    (full_vec[g])
    );
  end

  assign req       = nz_vec;
  assign enq_ready = !full_vec[enq_id];
  assign cfg_ready = !cfg_pend_q;
  assign prio_upt  = cfg_pend_q;

  // A held config write owns the cycle, which keeps ack and prio_upt mutually exclusive.
  assign gnt_ok  = is_onehot(gnt_w) && gnt_w[gnt_id] && (cnt_arr[gnt_id] != '0);
  assign dn_free = !dn_valid_q || dn_ready;
  assign ack     = !rst && gnt_ok && dn_free && !cfg_pend_q;

  always_comb begin
    inc_vec    = (enq_valid && enq_ready) ? (vec_t'(1) << enq_id) : '0;
    dec_vec    = ack ? (vec_t'(1) << gnt_id) : '0;

    dn_valid_d = dn_valid_q;
    dn_id_d    = dn_id_q;
    if (ack) begin
      dn_valid_d = 1'b1;
      dn_id_d    = gnt_id;
    end else if (dn_ready) begin
      dn_valid_d = 1'b0;
    end

    cfg_pend_d = 1'b0;
    prio_d     = prio_q;
    prio_id_d  = prio_id_q;
    if (cfg_valid && cfg_ready) begin
      cfg_pend_d = 1'b1;
      prio_d     = cfg_prio;
      prio_id_d  = cfg_id;
    end

    err_gnt_d = err_gnt_q || ((gnt_w != '0) && !gnt_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dn_valid_q <= 1'b0;
      dn_id_q    <= '0;
      cfg_pend_q <= 1'b0;
      prio_q     <= '0;
      prio_id_q  <= '0;
      err_gnt_q  <= 1'b0;
    end else begin
      dn_valid_q <= dn_valid_d;
      dn_id_q    <= dn_id_d;
      cfg_pend_q <= cfg_pend_d;
      prio_q     <= prio_d;
      prio_id_q  <= prio_id_d;
      err_gnt_q  <= err_gnt_d;
    end
  end

  assign dn_valid = dn_valid_q;
  assign dn_id    = dn_id_q;
  assign prio     = prio_q;
  assign prio_id  = prio_id_q;
  assign err_gnt  = err_gnt_q;
endmodule

// File: tb/tb_wrr_client.sv
// Directed bench for wrr_client: an integer-count model checked every cycle, plus literal checkpoints.
module tb_wrr_client;
  import wrr_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enq_valid = 1'b0;
  id_t           enq_id = '0;
  logic          enq_ready;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt_w = '0;
  id_t           gnt_id = '0;
  logic          ack;
  logic          dn_valid;
  id_t           dn_id;
  logic          dn_ready = 1'b0;
  logic          cfg_valid = 1'b0;
  id_t           cfg_id = '0;
  prio_t         cfg_prio = '0;
  logic          cfg_ready;
  prio_t         prio;
  id_t           prio_id;
  logic          prio_upt;
  logic          err_gnt;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  wrr_client dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_id(enq_id), .enq_ready(enq_ready),
    .req(req), .gnt_w(gnt_w), .gnt_id(gnt_id), .ack(ack),
    .dn_valid(dn_valid), .dn_id(dn_id), .dn_ready(dn_ready),
    .cfg_valid(cfg_valid), .cfg_id(cfg_id), .cfg_prio(cfg_prio), .cfg_ready(cfg_ready),
    .prio(prio), .prio_id(prio_id), .prio_upt(prio_upt), .err_gnt(err_gnt)
  );

  always #5 clk = ~clk;

  // Model: plain integer counts per requestor plus the few visible registers.
  int    m_cnt [N];
  bit    m_dnv, m_cfgp, m_err;
  int    m_dnid, m_prio, m_prio_id;
  localparam int CMAX = (1 << CNT_W) - 1;

  function automatic bit m_legal();
    return (gnt_w != '0) && ($countones(gnt_w) == 1) && gnt_w[gnt_id] && (m_cnt[int'(gnt_id)] > 0);
  endfunction

  function automatic bit m_ack();
    return !rst && m_legal() && (!m_dnv || dn_ready) && !m_cfgp;
  endfunction

  function automatic logic [N-1:0] m_req();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (m_cnt[i] > 0);
    return r;
  endfunction

  initial begin
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_dnv = 0; m_cfgp = 0; m_err = 0; m_dnid = 0; m_prio = 0; m_prio_id = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) m_cnt[i] <= 0;
      m_dnv <= 0; m_cfgp <= 0; m_err <= 0; m_dnid <= 0; m_prio <= 0; m_prio_id <= 0;
    end else begin
      for (int i = 0; i < N; i++)
        m_cnt[i] <= m_cnt[i]
                  + ((enq_valid && int'(enq_id) == i && m_cnt[i] < CMAX) ? 1 : 0)
                  - ((m_ack() && int'(gnt_id) == i) ? 1 : 0);
      if (m_ack()) begin
        m_dnv <= 1; m_dnid <= int'(gnt_id);
      end else if (dn_ready) begin
        m_dnv <= 0;
      end
      if (cfg_valid && !m_cfgp) begin
        m_cfgp <= 1; m_prio <= int'(cfg_prio); m_prio_id <= int'(cfg_id);
      end else begin
        m_cfgp <= 0;
      end
      if (gnt_w != '0 && !m_legal()) m_err <= 1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req",       64'(req),       64'(m_req()));
      chk("enq_ready", 64'(enq_ready), 64'(m_cnt[int'(enq_id)] < CMAX));
      chk("ack",       64'(ack),       64'(m_ack()));
      chk("dn_valid",  64'(dn_valid),  64'(m_dnv));
      chk("dn_id",     64'(dn_id),     64'(m_dnid));
      chk("cfg_ready", 64'(cfg_ready), 64'(!m_cfgp));
      chk("prio_upt",  64'(prio_upt),  64'(m_cfgp));
      chk("prio",      64'(prio),      64'(m_prio));
      chk("prio_id",   64'(prio_id),   64'(m_prio_id));
      chk("err_gnt",   64'(err_gnt),   64'(m_err));
      chk("excl",      64'(ack && prio_upt), 64'(0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic grant(input int id);
    gnt_w  = vec_t'(1) << id;
    gnt_id = id_t'(id);
  endtask

  initial begin
    tick();
    tick();
    chk_en = 1;
    rst = 1'b0;
    #1;
    chk("rst_req",   64'(req), 64'(0));
    chk("rst_ack",   64'(ack), 64'(0));
    chk("rst_dnv",   64'(dn_valid), 64'(0));
    chk("rst_cfgr",  64'(cfg_ready), 64'(1));
    chk("rst_enqr",  64'(enq_ready), 64'(1));
    chk("rst_err",   64'(err_gnt), 64'(0));

    // Two enqueues to id 3, then two back-to-back acks.
    enq_valid = 1'b1; enq_id = 5'd3;
    tick(); tick();
    enq_valid = 1'b0;
    grant(3); dn_ready = 1'b1;
    #1 chk("b2b_ack0", 64'(ack), 64'(1));
    tick();
    #1 chk("b2b_ack1", 64'(ack), 64'(1));
    chk("b2b_dnid0", 64'(dn_id), 64'(3));
    chk("b2b_req3a", 64'(req[3]), 64'(1));
    tick();
    gnt_w = '0;
    #1 chk("b2b_dnid1", 64'(dn_id), 64'(3));
    chk("b2b_req3b", 64'(req[3]), 64'(0));

    // Fill id 5, then enqueue and ack together at the full count.
    enq_valid = 1'b1; enq_id = 5'd5;
    repeat (15) tick();
    #1 chk("full_enqr", 64'(enq_ready), 64'(0));
    grant(5);
    #1 chk("full_ack", 64'(ack), 64'(1));
    chk("full_enqr2", 64'(enq_ready), 64'(0));
    tick();
    gnt_w = '0; dn_ready = 1'b0;
    #1 chk("after_enqr", 64'(enq_ready), 64'(1));
    enq_valid = 1'b0;

    // Backpressure: dn holds id 5 while a legal grant to id 3 waits.
    enq_valid = 1'b1; enq_id = 5'd3;
    tick();
    enq_valid = 1'b0;
    grant(3);
    #1 chk("bp_ack0", 64'(ack), 64'(0));
    tick();
    #1 chk("bp_ack1", 64'(ack), 64'(0));
    chk("bp_dnid", 64'(dn_id), 64'(5));
    chk("bp_dnv",  64'(dn_valid), 64'(1));
    dn_ready = 1'b1;
    #1 chk("bp_release", 64'(ack), 64'(1));
    tick();
    gnt_w = '0;
    #1 chk("bp_dnid2", 64'(dn_id), 64'(3));

    // Config write alongside a standing legal grant.
    grant(5);
    cfg_valid = 1'b1; cfg_id = 5'd7; cfg_prio = 4'd9;
    #1 chk("cfg_rdy", 64'(cfg_ready), 64'(1));
    tick();
    cfg_valid = 1'b0;
    #1 chk("cfg_upt", 64'(prio_upt), 64'(1));
    chk("cfg_prio", 64'(prio), 64'(9));
    chk("cfg_pid",  64'(prio_id), 64'(7));
    chk("cfg_ack",  64'(ack), 64'(0));
    tick();
    #1 chk("cfg_ack2", 64'(ack), 64'(1));
    chk("cfg_upt2", 64'(prio_upt), 64'(0));
    tick();
    gnt_w = '0;

    // Illegal grants: not one-hot, then a grant to an empty requestor.
    gnt_w = 32'h0000_0006; gnt_id = 5'd1;
    #1 chk("ill_ack", 64'(ack), 64'(0));
    chk("ill_err0", 64'(err_gnt), 64'(0));
    tick();
    gnt_w = '0;
    #1 chk("ill_err1", 64'(err_gnt), 64'(1));
    tick(); tick();
    #1 chk("ill_sticky", 64'(err_gnt), 64'(1));
    rst = 1'b1;
    #1 chk("rst_ack_forced", 64'(ack), 64'(0));
    tick();
    rst = 1'b0;
    #1 chk("rst2_err", 64'(err_gnt), 64'(0));
    chk("rst2_req", 64'(req), 64'(0));
    grant(9);
    #1 chk("empty_ack", 64'(ack), 64'(0));
    tick();
    gnt_w = '0;
    #1 chk("empty_err", 64'(err_gnt), 64'(1));
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/wrr_client.md
Name: wrr_client

Overview:
- Requestor-side counterpart of the weighted round-robin arbiter.
- Holds per-requestor pending-transaction counts and drives `req` from them.
- Consumes `gnt_w`/`gnt_id` and returns `ack`, forwarding each accepted grant as an ID on a registered valid/ready stream.
- Also owns the arbiter's weight-update interface, serialising config writes so `prio_upt` never coincides with `ack`.

Parameters:
- N, 32, number of requestors (matches arbiter N)
- PRIORITY_W, 4, weight width
- ID_BITS, $clog2(N), requestor ID width
- CNT_W, 4, per-requestor pending counter width (max 2^CNT_W-1 outstanding)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- enq_valid  in  1  submit one pending transaction
- enq_id  in  ID_BITS  requestor the transaction belongs to
- enq_ready  out  1  enq accepted when enq_valid&enq_ready
- req  out  N  to arbiter; req[i] = (cnt[i] != 0)
- gnt_w  in  N  one-hot grant from arbiter
- gnt_id  in  ID_BITS  encoded grant from arbiter
- ack  out  1  grant accepted this cycle
- dn_valid  out  1  granted-transaction stream valid
- dn_id  out  ID_BITS  granted requestor ID
- dn_ready  in  1  downstream accepts dn_id
- cfg_valid  in  1  weight write request
- cfg_id  in  ID_BITS  requestor whose weight is written
- cfg_prio  in  PRIORITY_W  new weight
- cfg_ready  out  1  cfg accepted when cfg_valid&cfg_ready
- prio  out  PRIORITY_W  to arbiter
- prio_id  out  ID_BITS  to arbiter
- prio_upt  out  1  to arbiter update strobe
- err_gnt  out  1  sticky protocol-error flag

Behaviour:
- Reset (rst=1 at a clk edge):
  - cnt[*]=0, dn_valid=0, dn_id=0, cfg_pend=0, prio=0, prio_id=0, err_gnt=0.
  - ack is forced 0 combinationally while rst=1.
  - After reset: req=0, enq_ready=1, cfg_ready=1.
  - Reset mid-operation discards all pending counts, any held cfg write and any dn entry; no ack is issued in the reset cycle.
- Enqueue:
  - enq_ready = (cnt[enq_id] != all-ones), combinational.
  - On accept, cnt[enq_id] increments at the next edge.
  - Full counter: enq_ready=0, even if an ack to the same ID occurs that cycle.
- Grant legality (combinational):
  - gnt_ok = gnt_w one-hot AND gnt_w[gnt_id]=1 AND req[gnt_id]=1.
  - gnt_w == 0 means no grant: no ack, no error.
  - gnt_w != 0 and !gnt_ok: ack=0; err_gnt sets at the next edge and holds until reset.
- Output slot: dn_free = !dn_valid | dn_ready.
- Ack rule: ack = !rst & gnt_ok & dn_free & !cfg_pend. This is combinational, same cycle as the grant, so latency is 0.
- On ack, at the next edge:
  - cnt[gnt_id] decrements.
  - dn_valid<=1 and dn_id<=gnt_id.
  - enq to the same ID in the same cycle gives a net count change of 0.
- dn stream:
  - dn_valid & dn_ready with no new ack clears dn_valid.
  - dn_id is stable while dn_valid & !dn_ready.
  - Back-to-back acks are possible when dn_ready=1 every cycle (1 ID/cycle throughput).
- Config write:
  - cfg_ready = !cfg_pend.
  - On accept: cfg_pend<=1, prio<=cfg_prio, prio_id<=cfg_id.
  - prio_upt = cfg_pend, registered. The next cycle presents prio_upt=1, ack is suppressed that cycle, and cfg_pend clears at the following edge.
  - Config therefore has priority over ack. ack and prio_upt are never both 1.
  - Max config rate: 1 write per 2 cycles.
- Counter wrap: decrement at 0 cannot occur because req[i]=0 makes such a grant illegal. Counters never wrap.

Decomposition:
- Package wrr_pkg holds:
  - Constants: N, PRIORITY_W, ID_BITS.
  - Typedefs: id_t (logic[ID_BITS-1:0]), prio_t, cnt_t (logic[CNT_W-1:0]).
  - Function is_onehot().
- Sub-module wrr_pend_counter, one per requestor via generate:
  - Inputs: clk, rst, inc, dec.
  - Outputs: cnt, nonzero, full.
  - Handles inc&dec = hold.
- Top level holds:
  - Grant check, ack logic, dn register and cfg holding register.

Test Plan:
- Reset, then idle: req=0, ack=0, dn_valid=0, cfg_ready=1, enq_ready=1, err_gnt=0.
- Enq id 3 twice, then drive gnt_w=1<<3, gnt_id=3 with dn_ready=1 for 2 cycles: ack=1 both cycles, dn_id=3 twice, req[3] falls after the 2nd edge.
- Enq id 5 15 times (CNT_W=4): enq_ready=0 on the 16th attempt. Enq id 5 plus ack id 5 in the same cycle at cnt=15: enq rejected, cnt=14.
- Hold dn_ready=0 with dn_valid=1 and a legal grant pending: ack=0 and dn_id stable. Raise dn_ready: ack=1 in the same cycle.
- cfg_valid, cfg_id=7, cfg_prio=9 while a legal grant is present: next cycle prio_upt=1, prio=9, prio_id=7, ack=0. The following cycle ack=1 and prio_upt=0.
- gnt_w=0x0000_0006 (not one-hot), or a grant to an ID with cnt=0: ack=0, err_gnt=1 from the next cycle until rst.
